// File: rtl/sticky_latch_bank_pkg.sv
// Shared definitions for the sticky latch bank: parameter limits, the
// EDGE_MODE encodings and the saturating-maximum helper.
package sticky_latch_bank_pkg;

  localparam int STICKY_WIDTH_MIN = 1;
  localparam int STICKY_WIDTH_MAX = 32;
  localparam int STICKY_CNT_W_MIN = 1;
  localparam int STICKY_CNT_W_MAX = 16;

  // How a push input turns into a set event.
  typedef enum logic {
    STICKY_LEVEL = 1'b0,
    STICKY_EDGE  = 1'b1
  } sticky_mode_e;

  // Largest value a cnt_w-bit saturating counter may hold (2^cnt_w - 1).
  function automatic logic [15:0] sat_max(input int cnt_w);
    return 16'((32'd1 << cnt_w) - 32'd1);
  endfunction

endpackage

// File: rtl/sticky_cell.sv
// One sticky channel: optional rising-edge detect on push, the sticky flag
// and a saturating event counter. flag_next exists only when STICKY_IRQ_EN
// is defined, because only the interrupt logic looks at the next flag value.
module sticky_cell
  import sticky_latch_bank_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int EDGE_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             clr_flag,
  input  logic             clr_cnt,
  output logic             flag,
`ifdef STICKY_IRQ_EN
  output logic             flag_next,
`endif
  output logic [CNT_W-1:0] cnt
);

  localparam logic IS_EDGE = (EDGE_MODE == int'(STICKY_EDGE));

  logic             r_push_q;
  logic             r_flag;
  logic [CNT_W-1:0] r_cnt;
  logic             w_set_ev;
  logic             w_flag_next;
  logic [CNT_W-1:0] w_cnt_max;

  assign w_cnt_max = CNT_W'(sat_max(CNT_W));

  // In level mode the delayed push is masked off, so push alone is the event.
  assign w_set_ev    = push & ~(r_push_q & IS_EDGE);
  // Set wins over a simultaneous clear, so no event is lost.
  assign w_flag_next = w_set_ev | (r_flag & ~clr_flag);

  // Push history, sticky flag and saturating counter.
  always_ff @(posedge clk) begin
    // NOTE: the counters are ordinary per-channel flops rather than a RAM, so
    // they take the synchronous reset along with the flag and push history.
    if (rst) begin
      r_push_q <= 1'b0;
      r_flag   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      r_push_q <= push;
      r_flag   <= w_flag_next;
      if (w_set_ev) begin
        if (clr_cnt)
          r_cnt <= CNT_W'(1);
        else if (r_cnt != w_cnt_max)
          r_cnt <= r_cnt + CNT_W'(1);
      end else if (clr_cnt) begin
        r_cnt <= '0;
      end
    end
  end

  assign flag = r_flag;
  assign cnt  = r_cnt;
`ifdef STICKY_IRQ_EN
  assign flag_next = w_flag_next;
`endif

endmodule

// File: rtl/sticky_latch_bank.sv
// Bank of WIDTH sticky flags with per-channel saturating event counters,
// W1C clearing from the shared bus, a gated bus driver and a counter mux.
// Optional feature macro: STICKY_IRQ_EN adds mask_we, irq and an interrupt
// mask register loaded from bus_in.
module sticky_latch_bank
  import sticky_latch_bank_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 4,
  parameter int EDGE_MODE = 0,
  parameter int SEL_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] push,
  input  logic             clr_all,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             bus_we,
  input  logic             bus_oe,
  output logic [WIDTH-1:0] bus_out,
  output logic [WIDTH-1:0] latched,
  output logic             any_set,
  input  logic [SEL_W-1:0] cnt_sel,
  output logic [CNT_W-1:0] cnt_out
`ifdef STICKY_IRQ_EN
  ,
  input  logic             mask_we,
  output logic             irq
`endif
);

  // Elaboration-time parameter sanity checks.
  if (WIDTH < STICKY_WIDTH_MIN || WIDTH > STICKY_WIDTH_MAX) begin : g_bad_width
    $error("sticky_latch_bank: WIDTH out of range");
  end
  if (CNT_W < STICKY_CNT_W_MIN || CNT_W > STICKY_CNT_W_MAX) begin : g_bad_cnt_w
    $error("sticky_latch_bank: CNT_W out of range");
  end
  if (SEL_W < 1 || SEL_W < $clog2(WIDTH)) begin : g_bad_sel_w
    $error("sticky_latch_bank: SEL_W too narrow for WIDTH");
  end

  logic [WIDTH-1:0]            w_w1c;
  logic [WIDTH-1:0]            w_clr;
  logic [WIDTH-1:0]            w_latched;
  logic [WIDTH-1:0][CNT_W-1:0] w_cnt;

`ifdef STICKY_IRQ_EN
  logic [WIDTH-1:0] w_latched_next;
  logic [WIDTH-1:0] r_irq_mask;
  logic             r_irq;

  // A mask load borrows the bus write, so it must not also clear flags.
  assign w_w1c = (bus_we && !mask_we) ? bus_in : '0;
`else
  assign w_w1c = bus_we ? bus_in : '0;
`endif

  assign w_clr = {WIDTH{clr_all}} | w_w1c;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    sticky_cell #(
      .CNT_W     (CNT_W),
      .EDGE_MODE (EDGE_MODE)
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .push      (push[g]),
      .clr_flag  (w_clr[g]),
      .clr_cnt   (clr_all),
      .flag      (w_latched[g]),
`ifdef STICKY_IRQ_EN
      .flag_next (w_latched_next[g]),
`endif
      .cnt       (w_cnt[g])
    );
  end

  assign latched = w_latched;
  assign any_set = |w_latched;
  assign bus_out = w_latched & {WIDTH{bus_oe}};

  // Counter read mux; out-of-range selects read as zero.
  always_comb begin
    // NOTE: default assigned first so an unmatched select cannot infer a latch.
    cnt_out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt_sel == SEL_W'(i))
        cnt_out = w_cnt[i];
    end
  end

`ifdef STICKY_IRQ_EN
  // Interrupt mask register and registered interrupt from the next flag state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_mask <= '1;
      r_irq      <= 1'b0;
    end else begin
      if (bus_we && mask_we)
        r_irq_mask <= bus_in;
      r_irq <= |(w_latched_next & r_irq_mask);
    end
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_sticky_latch_bank.sv
// Self-checking bench for sticky_latch_bank. Instance A: level mode, WIDTH=8,
// CNT_W=4, checked against a behavioural model through a scoreboard queue.
// Instance B: edge mode, WIDTH=4, CNT_W=2, hand-derived expectations.
module tb_sticky_latch_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [7:0] a_push, a_bus_in, a_bus_out, a_latched;
  logic       a_clr_all, a_bus_we, a_bus_oe, a_any_set;
  logic [2:0] a_cnt_sel;
  logic [3:0] a_cnt_out;

  logic [3:0] b_push, b_bus_in, b_bus_out, b_latched;
  logic       b_clr_all, b_bus_we, b_bus_oe, b_any_set;
  logic [2:0] b_cnt_sel;
  logic [1:0] b_cnt_out;

`ifdef STICKY_IRQ_EN
  logic a_mask_we, a_irq, b_mask_we, b_irq;
`endif

  sticky_latch_bank #(.WIDTH(8), .CNT_W(4), .EDGE_MODE(0), .SEL_W(3)) u_dut_a (
    .clk(clk), .rst(rst), .push(a_push), .clr_all(a_clr_all),
    .bus_in(a_bus_in), .bus_we(a_bus_we), .bus_oe(a_bus_oe),
    .bus_out(a_bus_out), .latched(a_latched), .any_set(a_any_set),
    .cnt_sel(a_cnt_sel), .cnt_out(a_cnt_out)
`ifdef STICKY_IRQ_EN
    , .mask_we(a_mask_we), .irq(a_irq)
`endif
  );

  sticky_latch_bank #(.WIDTH(4), .CNT_W(2), .EDGE_MODE(1), .SEL_W(3)) u_dut_b (
    .clk(clk), .rst(rst), .push(b_push), .clr_all(b_clr_all),
    .bus_in(b_bus_in), .bus_we(b_bus_we), .bus_oe(b_bus_oe),
    .bus_out(b_bus_out), .latched(b_latched), .any_set(b_any_set),
    .cnt_sel(b_cnt_sel), .cnt_out(b_cnt_out)
`ifdef STICKY_IRQ_EN
    , .mask_we(b_mask_we), .irq(b_irq)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    string      tag;
    logic [7:0] lat;
    logic [3:0] cnt;
    logic [7:0] bus;
    logic       any;
    logic       irq;
  } a_exp_t;

  typedef struct {
    string      tag;
    logic [3:0] lat;
    logic [1:0] cnt;
  } b_exp_t;

  a_exp_t sb_a[$];
  b_exp_t sb_b[$];

  // Behavioural model of instance A.
  logic [7:0] m_lat;
  int         m_cnt [8];
  logic [7:0] m_mask;
  logic       m_irq;

  task automatic model_reset();
    m_lat  = '0;
    m_mask = 8'hFF;
    m_irq  = 1'b0;
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
  endtask

  // Two reset cycles with pushes held high; B keeps b_hold on push afterwards.
  task automatic do_reset(input logic [3:0] b_hold);
    @(negedge clk);
    rst = 1'b1; a_push = 8'hFF; b_push = b_hold; a_bus_oe = 1'b1;
    a_clr_all = 1'b0; a_bus_we = 1'b0; b_clr_all = 1'b0; b_bus_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_a_latched", 32'(a_latched), 32'h0);
    check("rst_a_bus_out", 32'(a_bus_out), 32'h0);
    check("rst_a_any_set", 32'(a_any_set), 32'h0);
    check("rst_b_latched", 32'(b_latched), 32'h0);
`ifdef STICKY_IRQ_EN
    check("rst_a_irq", 32'(a_irq), 32'h0);
`endif
    for (int s = 0; s < 8; s++) begin
      a_cnt_sel = 3'(s);
      #1;
      check($sformatf("rst_a_cnt%0d", s), 32'(a_cnt_out), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0; a_push = 8'h00;
  endtask

  // One cycle of instance A: drive, predict, push expectation, then compare.
  task automatic a_cycle(input string tag, input logic [7:0] push, input logic clr_all,
                         input logic we, input logic [7:0] bin, input logic oe,
                         input logic [2:0] sel, input logic mwe);
    logic [7:0] clr, nlat;
    a_exp_t e, o;
    @(negedge clk);
    a_push = push; a_clr_all = clr_all; a_bus_we = we; a_bus_in = bin;
    a_bus_oe = oe; a_cnt_sel = sel;
`ifdef STICKY_IRQ_EN
    a_mask_we = mwe;
`endif
    clr  = {8{clr_all}} | ((we && !mwe) ? bin : 8'h00);
    nlat = push | (m_lat & ~clr);
    for (int i = 0; i < 8; i++) begin
      if (clr_all) m_cnt[i] = push[i] ? 1 : 0;
      else if (push[i] && m_cnt[i] < 15) m_cnt[i]++;
    end
    m_irq = |(nlat & m_mask);
    if (we && mwe) m_mask = bin;
    m_lat = nlat;
    e.tag = tag; e.lat = m_lat; e.cnt = 4'(m_cnt[sel]);
    e.bus = oe ? m_lat : 8'h00; e.any = |m_lat; e.irq = m_irq;
    sb_a.push_back(e);
    @(posedge clk);
    #1;
    o = sb_a.pop_front();
    check({o.tag, "_lat"}, 32'(a_latched), 32'(o.lat));
    check({o.tag, "_cnt"}, 32'(a_cnt_out), 32'(o.cnt));
    check({o.tag, "_bus"}, 32'(a_bus_out), 32'(o.bus));
    check({o.tag, "_any"}, 32'(a_any_set), 32'(o.any));
`ifdef STICKY_IRQ_EN
    check({o.tag, "_irq"}, 32'(a_irq), 32'(o.irq));
`endif
  endtask

  // One cycle of instance B with hand-derived expectations.
  task automatic b_cycle(input string tag, input logic [3:0] push, input logic [2:0] sel,
                         input logic [3:0] exp_lat, input logic [1:0] exp_cnt);
    b_exp_t e, o;
    @(negedge clk);
    b_push = push; b_cnt_sel = sel;
    e.tag = tag; e.lat = exp_lat; e.cnt = exp_cnt;
    sb_b.push_back(e);
    @(posedge clk);
    #1;
    o = sb_b.pop_front();
    check({o.tag, "_lat"}, 32'(b_latched), 32'(o.lat));
    check({o.tag, "_cnt"}, 32'(b_cnt_out), 32'(o.cnt));
    check({o.tag, "_bus"}, 32'(b_bus_out), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    a_push = '0; a_clr_all = 1'b0; a_bus_in = '0; a_bus_we = 1'b0; a_bus_oe = 1'b0; a_cnt_sel = '0;
    b_push = '0; b_clr_all = 1'b0; b_bus_in = '0; b_bus_we = 1'b0; b_bus_oe = 1'b0; b_cnt_sel = '0;
`ifdef STICKY_IRQ_EN
    a_mask_we = 1'b0; b_mask_we = 1'b0;
`endif
    model_reset();

    do_reset(4'b0010);

    // Edge mode: push held through reset counts once, then pulses saturate at 3.
    b_cycle("b_edge_after_rst", 4'b0010, 3'd1, 4'b0010, 2'd1);
    for (int k = 2; k <= 10; k++) b_cycle("b_held", 4'b0010, 3'd1, 4'b0010, 2'd1);
    for (int k = 1; k <= 5; k++) begin
      b_cycle("b_pulse_low",  4'b0000, 3'd1, 4'b0010, 2'((k     > 3) ? 3 : k));
      b_cycle("b_pulse_high", 4'b0010, 3'd1, 4'b0010, 2'((k + 1 > 3) ? 3 : k + 1));
    end
    b_cycle("b_sel_oob", 4'b0000, 3'd5, 4'b0010, 2'd0);

    // Level mode: single push then idle; flag sticks, counter is 1.
    a_cycle("a_push0", 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0);
    for (int k = 0; k < 5; k++) a_cycle("a_idle", 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0);
    // W1C on bit 2 leaves its counter alone.
    a_cycle("a_push2", 8'h04, 1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 1'b0);
    a_cycle("a_w1c2",  8'h00, 1'b0, 1'b1, 8'h04, 1'b1, 3'd2, 1'b0);
    // Set with clr_all: set wins, counter restarts at 1, others cleared.
    a_cycle("a_set_clrall", 8'h08, 1'b1, 1'b0, 8'h00, 1'b1, 3'd3, 1'b0);
    a_cycle("a_cnt0_cleared", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    // Set and W1C on the same bit: set wins.
    a_cycle("a_set_w1c", 8'h02, 1'b0, 1'b1, 8'h0A, 1'b1, 3'd1, 1'b0);
    // Saturation at 15.
    for (int k = 0; k < 20; k++) a_cycle("a_sat", 8'h20, 1'b0, 1'b0, 8'h00, 1'b1, 3'd5, 1'b0);
    // Random traffic against the model.
    for (int k = 0; k < 40; k++)
      a_cycle("a_rand", 8'($urandom & $urandom), ($urandom_range(0, 15) == 0),
              1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), 1'b0);

`ifdef STICKY_IRQ_EN
    a_cycle("a_irq_clr",  8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0);
    a_cycle("a_irq_mask", 8'h00, 1'b0, 1'b1, 8'h02, 1'b1, 3'd0, 1'b1);
    a_cycle("a_irq_p0",   8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0);
    a_cycle("a_irq_p1",   8'h02, 1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0);
    a_cycle("a_irq_hold", 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0);
`endif

    // Reset in the middle of activity.
    a_cycle("a_pre_rst", 8'hC3, 1'b0, 1'b0, 8'h00, 1'b1, 3'd7, 1'b0);
    do_reset(4'b0000);
    a_cycle("a_post_rst", 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 3'd7, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
